feature_arbiter: RTL

Two-channel feature arbiter placed in front of the feature conflict check between Input Interface 01 (IE01) and Input Interface 02 (IE02). Each interface requests a 3-bit feature code. The arbiter grants both channels when their features differ, and serialises them when they collide. It uses a round-robin priority bit and a bounded hold timer, so a channel waiting on a contended feature is guaranteed service. `cftout` keeps the team's polarity: 1 = passed (no conflict), 0 = conflict.

---
 rtl/feature_arbiter_if.sv | 23 ++
 rtl/feature_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/feature_arbiter_if.sv
// Request/grant bundle between the two input interfaces (IE01, IE02) and the
// feature arbiter.
interface feature_arbiter_if;
    logic       req1;
    logic [2:0] feat1;
    logic       req2;
    logic [2:0] feat2;
    logic       gnt1;
    logic       gnt2;
    logic [2:0] act1;
    logic [2:0] act2;
    logic       cftout;

    modport master (
        output req1, feat1, req2, feat2,
        input  gnt1, gnt2, act1, act2, cftout
    );

    modport slave (
        input  req1, feat1, req2, feat2,
        output gnt1, gnt2, act1, act2, cftout
    );
endinterface

// File: rtl/feature_arbiter.sv
// Two-channel feature arbiter: grants both channels on distinct feature codes,
// serialises colliding codes with round-robin priority and a bounded hold.
module feature_arbiter_chan #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic [2:0] feat_i,
    input  logic       oth_act_i,
    input  logic [2:0] oth_lf_i,
    input  logic       oth_req_i,
    input  logic [2:0] oth_feat_i,
    input  logic       oth_fav_i,
    input  logic       oth_exp_i,
    output logic       act_o,
    output logic [2:0] lf_o,
    output logic       exp_o,
    output logic       blocked_o,
    output logic       take_o
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] lf_q, lf_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hand_in, hand_out;

    // Blocking is judged on pre-edge state only, so a normal release costs
    // the waiter one idle cycle; a forced handover bypasses the block.
    assign blocked_o = (state_q == IDLE) && req_i &&
                       ((oth_act_i && (oth_lf_i == feat_i)) ||
                        (!oth_act_i && oth_req_i && (oth_feat_i == feat_i) && oth_fav_i));
    assign hand_in   = (state_q == IDLE) && req_i && oth_exp_i && (oth_lf_i == feat_i);
    assign hand_out  = exp_o && !oth_act_i && oth_req_i && (oth_feat_i == lf_q);
    assign exp_o     = (state_q == ACTIVE) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        lf_d    = lf_q;
        cnt_d   = cnt_q;
        take_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i && (!blocked_o || hand_in)) begin
                    state_d = ACTIVE;
                    lf_d    = feat_i;
                    cnt_d   = '0;
                    take_o  = 1'b1;
                end
            end
            ACTIVE: begin
                if (!req_i || hand_out) begin
                    state_d = IDLE;
                    lf_d    = '0;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lf_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lf_q    <= lf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign act_o = (state_q == ACTIVE);
    assign lf_o  = lf_q;
endmodule

module feature_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    feature_arbiter_if.slave  bus
);
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0]      req, act, expiring, blocked, take;
    logic [NUM_CH-1:0][2:0] feat, lf;
    logic                   prio_q, prio_d;
    logic                   cftout_q, cftout_d;

    assign req  = {bus.req2, bus.req1};
    assign feat = {bus.feat2, bus.feat1};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam int O = NUM_CH - 1 - g;
        feature_arbiter_chan #(.MAX_HOLD(MAX_HOLD)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .req_i      (req[g]),
            .feat_i     (feat[g]),
            .oth_act_i  (act[O]),
            .oth_lf_i   (lf[O]),
            .oth_req_i  (req[O]),
            .oth_feat_i (feat[O]),
            .oth_fav_i  (prio_q == 1'(O)),
            .oth_exp_i  (expiring[O]),
            .act_o      (act[g]),
            .lf_o       (lf[g]),
            .exp_o      (expiring[g]),
            .blocked_o  (blocked[g]),
            .take_o     (take[g])
        );
    end

    // A lone grant hands priority to the other channel; simultaneous grants
    // (distinct codes) leave it alone.
    always_comb begin
        prio_d = prio_q;
        if (take == 2'b01)
            prio_d = 1'b1;
        else if (take == 2'b10)
            prio_d = 1'b0;
        cftout_d = ~|blocked;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= 1'b0;
            cftout_q <= 1'b1;
        end else begin
            prio_q   <= prio_d;
            cftout_q <= cftout_d;
        end
    end

    assign bus.gnt1   = act[0];
    assign bus.gnt2   = act[1];
    assign bus.act1   = lf[0];
    assign bus.act2   = lf[1];
    assign bus.cftout = cftout_q;
endmodule
